// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding request at a
// time to a variable-latency instruction memory and buffers fetched words for decode.
module fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                PC_STEP  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_ack,
  input  logic [DATA_W-1:0]            imem_data,
  output logic                         inst_valid,
  output logic [DATA_W-1:0]            inst_data,
  output logic [ADDR_W-1:0]            inst_pc,
  output logic [ADDR_W-1:0]            inst_pc_inc,
  input  logic                         inst_ready,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         stop,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int                CW      = $clog2(DEPTH+1);
  localparam int                PW      = $clog2(DEPTH);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  // Handshakes: a memory request completes on any edge with imem_req=1 and imem_ack=1,
  // and req/addr stay frozen until then; decode takes the head on any edge with
  // inst_valid=1 and inst_ready=1, unless redirect flushes the queue in that same edge.
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stale_q, stale_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              ack_acc;
  logic              pending;
  logic              enq;
  logic              deq;
  logic              launch;
  logic [CW-1:0]     occ_next;
  logic [ADDR_W-1:0] pc_src;

  always_comb begin
    ack_acc  = req_q & imem_ack;
    pending  = req_q & ~imem_ack;
    enq      = ack_acc & ~stale_q & ~redirect;
    deq      = (count_q != '0) & inst_ready & ~redirect;
    occ_next = redirect ? '0 : (count_q + CW'(enq) - CW'(deq));
    // Credit check covers the one request that can be in flight, so the queue never overflows.
    launch   = ~pending & ~stop & (occ_next < DEPTH_C);
    pc_src   = redirect ? redirect_pc : fetch_pc_q;

    fetch_pc_d = launch ? (pc_src + STEP_C) : pc_src;
    req_d      = launch | pending;
    addr_d     = launch ? pc_src : addr_q;
    count_d    = occ_next;

    stale_d = stale_q;
    if (redirect && pending) begin
      stale_d = 1'b1;
    end else if (ack_acc) begin
      stale_d = 1'b0;
    end

    wr_ptr_d = redirect ? '0 : (wr_ptr_q + PW'(enq));
    rd_ptr_d = redirect ? '0 : (rd_ptr_q + PW'(deq));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      stale_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: count gates every read through inst_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[wr_ptr_q] <= imem_data;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = (count_q != '0);
  assign inst_data   = data_mem[rd_ptr_q];
  assign inst_pc     = pc_mem[rd_ptr_q];
  assign inst_pc_inc = pc_mem[rd_ptr_q] + STEP_C;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios, behavioural instruction memory with
// programmable latency, and a scoreboard of expected head PCs checked on every pop.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_inc;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stop;
  logic [2:0]  count;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [15:0] w_data;
  logic        w_valid;
  logic [15:0] w_inst_data;
  logic [15:0] w_inst_pc;
  logic [15:0] w_inst_pc_inc;
  logic        w_ready;
  logic        w_redirect;
  logic [15:0] w_redirect_pc;
  logic        w_stop;
  logic [2:0]  w_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 0;
  int          wait_cnt = 0;
  int          ack_cnt  = 0;
  logic        force_ack;
  logic [15:0] exp_q[$];

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc_inc(inst_pc_inc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .stop(stop), .count(count)
  );

  fetch_queue #(.RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
    .inst_valid(w_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
    .inst_pc_inc(w_inst_pc_inc), .inst_ready(w_ready),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .stop(w_stop), .count(w_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  always_comb begin
    imem_ack  = (imem_req && (wait_cnt >= lat)) || force_ack;
    imem_data = mem_word(imem_addr);
    w_ack     = w_req;
    w_data    = mem_word(w_addr);
  end

  always @(posedge clk) begin
    if (imem_req && imem_ack) begin
      wait_cnt <= 0;
      ack_cnt  <= ack_cnt + 1;
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_req", imem_req, 0);
    check("rst_count", count, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_wrap_addr", w_addr, 16'hFFFC);
    rst = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [15:0] a);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (imem_req && imem_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_req_addr", found, 1);
  endtask

  task automatic drain();
    logic idle;
    stop       = 1'b1;
    inst_ready = 1'b1;
    idle       = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!imem_req && count == 0) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    check("drain_idle", idle, 1);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [15:0] exp_pc;
    logic [15:0] exp_inc;
    if (!rst && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0h expected no entry", inst_pc);
      end else begin
        exp_pc  = exp_q.pop_front();
        exp_inc = exp_pc + 16'd2;
        check("head_pc", inst_pc, exp_pc);
        check("head_data", inst_data, mem_word(exp_pc));
        check("head_pc_inc", inst_pc_inc, exp_inc);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [15:0] e;
    logic        seen;
    int          base;
    int          bad;
    rst = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    stop = 1'b0; force_ack = 1'b0;
    w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 16'h0000; w_stop = 1'b0;

    // A: zero-wait streaming, plus the wrapping instance
    lat = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(2 * i));
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      e = 16'(2 * i);
      check("stream_addr", imem_addr, e);
      check("stream_req", imem_req, 1);
      if (i == 1) check("stream_head_pc", inst_pc, 16'h0000);
      if (i < 3) begin
        e = 16'hFFFC + 16'(2 * i);
        check("wrap_addr", w_addr, e);
      end
      if (i == 2) begin
        check("wrap_valid", w_valid, 1);
        check("wrap_pc", w_inst_pc, 16'hFFFE);
        check("wrap_pc_inc", w_inst_pc_inc, 16'h0000);
        check("wrap_data", w_inst_data, mem_word(16'hFFFE));
      end
    end
    drain();

    // B: decode stalled, credit limit at DEPTH entries
    stop = 1'b0; inst_ready = 1'b0; lat = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back(16'(2 * i));
    do_reset();
    base = ack_cnt;
    for (int i = 0; i < 8; i++) tick();
    check("full_count", count, 4);
    check("full_req", imem_req, 0);
    check("full_acks", ack_cnt - base, 4);
    check("full_head_pc", inst_pc, 16'h0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("pop_req", imem_req, 1);
    check("pop_addr", imem_addr, 16'h0008);
    check("pop_count", count, 3);
    tick();
    check("refill_count", count, 4);
    check("refill_req", imem_req, 0);
    drain();

    // C: redirect while a slow request is in flight
    stop = 1'b0; inst_ready = 1'b1; lat = 3;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    do_reset();
    wait_req_addr(16'h0004);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check("redir_count", count, 0);
    check("redir_hold_req", imem_req, 1);
    check("redir_hold_addr", imem_addr, 16'h0004);
    exp_q.push_back(16'h0100);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (imem_ack) begin
        seen = 1'b1;
        break;
      end
      check("stale_hold_addr", imem_addr, 16'h0004);
      tick();
    end
    check("stale_ack_seen", seen, 1);
    tick();
    check("redir_new_addr", imem_addr, 16'h0100);
    check("redir_new_req", imem_req, 1);
    check("redir_new_count", count, 0);
    drain();

    // D: redirect in the same cycle as an ack, two entries queued
    stop = 1'b0; inst_ready = 1'b0; lat = 2;
    do_reset();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (count == 2) begin
        seen = 1'b1;
        break;
      end
    end
    check("d_two_queued", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (imem_ack) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("d_ack_seen", seen, 1);
    check("d_count_at_ack", count, 2);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("d_count", count, 0);
    check("d_valid", inst_valid, 0);
    check("d_addr", imem_addr, 16'h0040);
    check("d_req", imem_req, 1);
    exp_q.push_back(16'h0040);
    drain();

    // E: stop while a request is outstanding, then resume
    stop = 1'b0; inst_ready = 1'b1; lat = 2;
    for (int i = 0; i < 7; i++) exp_q.push_back(16'(2 * i));
    do_reset();
    wait_req_addr(16'h000A);
    stop = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (imem_req && imem_addr != 16'h000A) bad++;
    end
    check("stop_no_launch", bad, 0);
    check("stop_req", imem_req, 0);
    check("stop_count", count, 0);
    stop = 1'b0;
    tick();
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 16'h000C);
    drain();

    // G: reset abandons an outstanding request; a stray ack is ignored
    stop = 1'b0; inst_ready = 1'b1; lat = 5;
    do_reset();
    tick();
    tick();
    check("g_outstanding", imem_req, 1);
    rst = 1'b1;
    tick();
    check("g_abandon_req", imem_req, 0);
    stop = 1'b1;
    rst = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    check("g_stray_count", count, 0);
    check("g_stray_valid", inst_valid, 0);
    check("g_stray_req", imem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the next-generation WISC core. It replaces the single-cycle core's combinational PC-to-instruction-memory path. The block owns the fetch PC and issues requests to a variable-latency instruction memory over a req/ack handshake. Fetched words are buffered in a DEPTH-entry queue that presents {instruction, PC, PC+step} to decode under valid/ready, with branch redirect (flush) and halt (stop) support.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, instruction width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 16'h0000, fetch PC after reset
PC_STEP, 2, byte increment per instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request, registered
imem_addr  out  ADDR_W  fetch address, registered
imem_ack  in  1  response strobe; imem_data valid this cycle
imem_data  in  DATA_W  instruction word
inst_valid  out  1  queue head valid
inst_data  out  DATA_W  head instruction
inst_pc  out  ADDR_W  head PC
inst_pc_inc  out  ADDR_W  inst_pc + PC_STEP, mod 2^ADDR_W
inst_ready  in  1  decode accepts head
redirect  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch PC
stop  in  1  halt: launch no new requests
count  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset: clk and rst as above, synchronous and active-high. Reset clears imem_req, count, inst_valid, and the stale flag. It sets fetch PC = RESET_PC and imem_addr = RESET_PC.
- Reset mid-transaction: an outstanding request is abandoned. A later ack with imem_req=0 is ignored.
- Handshake: at most one request outstanding. Once raised, imem_req and imem_addr hold stable until an edge where imem_ack=1. imem_ack with imem_req=0 is ignored. Data is captured at the ack edge.
- Launch rule: at each edge, a new request is launched (imem_req<=1, imem_addr<=fetch PC, fetch PC += PC_STEP) when all of the following hold:
  - no request remains outstanding after this edge;
  - stop=0;
  - occ_next + 1 <= DEPTH, where occ_next is the occupancy after this edge's enqueue, dequeue and flush.
- Otherwise imem_req<=0 once acked.
- Throughput: with zero-wait memory (ack in the same cycle as req), imem_req stays high with the address advancing by PC_STEP every cycle: 1 instruction per clock.
- Enqueue: ack with the stale flag clear writes {imem_data, imem_addr} at the tail.
- Dequeue: inst_valid & inst_ready pops the head.
- Enqueue and dequeue in the same edge: count unchanged.
- Full: can never overflow, because of the credit check.
- Empty: inst_valid=0. There is no bypass, so an acked word appears at the head no earlier than the cycle after the ack edge.
- Head outputs come straight from storage; inst_data, inst_pc and inst_pc_inc are don't-care while inst_valid=0.
- Redirect (priority over everything else in the same edge):
  - count<=0; any dequeue that cycle is void; fetch PC <= redirect_pc.
  - If a request remains outstanding after the edge, set stale. The request holds its address until ack, its data is dropped, and stale clears at that ack.
  - If the ack lands in the redirect cycle itself, drop that data. The next request may launch at that same edge with imem_addr=redirect_pc.
- Stop:
  - blocks launches only; an outstanding request still completes and enqueues;
  - draining continues;
  - redirect during stop still flushes and loads the PC;
  - fetch resumes on the first edge with stop=0.
- Wrap: fetch PC, pointers and inst_pc_inc wrap modulo their widths, with no error.

Test Plan:
- Reset then zero-wait memory (ack = req), inst_ready=1 -> imem_addr 0x0000, 0x0002, 0x0004… on consecutive cycles; inst_pc follows one cycle behind the ack; inst_pc_inc = inst_pc+2.
- inst_ready=0, DEPTH=4, zero-wait -> exactly 4 acks, count=4, imem_req=0. One pop -> one new request at 0x0008.
- Memory latency 3 cycles, redirect to 0x0100 on the cycle after req(0x0004) -> imem_addr holds 0x0004 until its ack; that data is dropped; next req at 0x0100; count=0 after the redirect.
- Redirect to 0x0040 on the same cycle as an ack, with 2 entries queued -> nothing enqueued; count=0; imem_addr=0x0040 on the next cycle.
- stop=1 while req(0x000A) outstanding, latency 2 -> 0x000A enqueued; no further req while stop=1; after stop=0, next req at 0x000C.
- RESET_PC=16'hFFFC, zero-wait -> addresses 0xFFFC, 0xFFFE, 0x0000; inst_pc_inc for 0xFFFE = 0x0000.
